sync_fifo_mem: RTL and testbench

Single-clock synchronous FIFO built around a parametrised dual-port storage array. It adds full/empty flags, programmable almost-full/almost-empty thresholds, an occupancy count, a registered read port and sticky overflow/underflow error flags. It serves as the drop-in buffer for same-clock producer/consumer paths where a crossing FIFO is unnecessary.

---
 rtl/sync_fifo_mem_if.sv | 30 +++
 rtl/sync_fifo_mem.sv | 75 +++++++
 tb/tb_sync_fifo_mem.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_mem_if.sv
// Handshake bundle between a producer/consumer and sync_fifo_mem.
interface sync_fifo_mem_if #(
    parameter int unsigned DATASIZE = 32,
    parameter int unsigned ADDRSIZE = 5
);
    logic                wclken;
    logic [DATASIZE-1:0] wdata;
    logic                rinc;
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                wfull;
    logic                rempty;
    logic                afull;
    logic                aempty;
    logic [ADDRSIZE:0]   count;
    logic                overflow;
    logic                underflow;

    // Producer/consumer side.
    modport master (
        output wclken, wdata, rinc,
        input  rdata, rvalid, wfull, rempty, afull, aempty, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  wclken, wdata, rinc,
        output rdata, rvalid, wfull, rempty, afull, aempty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO: dual-port array, wrap-bit pointers, registered read port,
// registered occupancy flags and sticky overflow/underflow.
module sync_fifo_mem #(
    parameter int unsigned DATASIZE      = 32,
    parameter int unsigned ADDRSIZE      = 5,
    parameter int unsigned AFULL_THRESH  = (1 << ADDRSIZE) - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic               wclk,
    input  logic               wrst,
    sync_fifo_mem_if.slave     bus
);
    localparam int unsigned DEPTH = 1 << ADDRSIZE;
    localparam int unsigned PW    = ADDRSIZE + 1;

    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [PW-1:0]       wptr_nxt;
    logic [PW-1:0]       rptr_nxt;
    logic [PW-1:0]       count_nxt;
    logic                wr_ok;
    logic                rd_ok;

    // Accept decisions gated by the pre-edge flags, and the next pointer/occupancy.
    always_comb begin
        wr_ok     = bus.wclken && !bus.wfull;
        rd_ok     = bus.rinc && !bus.rempty;
        wptr_nxt  = wptr + PW'(wr_ok);
        rptr_nxt  = rptr + PW'(rd_ok);
        count_nxt = wptr_nxt - rptr_nxt;
    end

    // Storage write port; contents survive reset since reads never reach stale words.
    always_ff @(posedge wclk) begin
        if (wr_ok) begin
            mem[wptr[ADDRSIZE-1:0]] <= bus.wdata;
        end
    end

    // Pointers, occupancy flags, registered read port and sticky errors.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr          <= '0;
            rptr          <= '0;
            bus.count     <= '0;
            bus.wfull     <= 1'b0;
            bus.rempty    <= 1'b1;
            bus.afull     <= 1'b0;
            bus.aempty    <= 1'b1;
            bus.rdata     <= '0;
            bus.rvalid    <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            wptr          <= wptr_nxt;
            rptr          <= rptr_nxt;
            bus.count     <= count_nxt;
            bus.wfull     <= (count_nxt == DEPTH_C);
            bus.rempty    <= (count_nxt == '0);
            bus.afull     <= (count_nxt >= AFULL_C);
            bus.aempty    <= (count_nxt <= AEMPTY_C);
            bus.rvalid    <= rd_ok;
            if (rd_ok) begin
                bus.rdata <= mem[rptr[ADDRSIZE-1:0]];
            end
            bus.overflow  <= bus.overflow  | (bus.wclken & bus.wfull);
            bus.underflow <= bus.underflow | (bus.rinc & bus.rempty);
        end
    end
endmodule

// File: tb/tb_sync_fifo_mem.sv
// Directed bench for sync_fifo_mem: default 32-deep instance plus a 4-deep sweep instance.
module tb_sync_fifo_mem;
    logic wclk;
    logic wrst;
    int   n_cmp;
    int   n_err;

    sync_fifo_mem_if #(.DATASIZE(32), .ADDRSIZE(5)) bus ();
    sync_fifo_mem_if #(.DATASIZE(8),  .ADDRSIZE(2)) sbus ();

    sync_fifo_mem #(.DATASIZE(32), .ADDRSIZE(5), .AFULL_THRESH(28), .AEMPTY_THRESH(4)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    sync_fifo_mem #(.DATASIZE(8), .ADDRSIZE(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut_s (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (sbus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.wclken  = 1'b0;
        bus.rinc    = 1'b0;
        bus.wdata   = '0;
        sbus.wclken = 1'b0;
        sbus.rinc   = 1'b0;
        sbus.wdata  = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        wrst = 1'b1;
        tick();
        tick();
        wrst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [8:0] flags;
        do_reset();
        // {wfull,rempty,afull,aempty,rvalid,overflow,underflow} plus count/rdata
        flags = {bus.wfull, bus.rempty, bus.afull, bus.aempty, bus.rvalid, bus.overflow, bus.underflow, 2'b00};
        n_cmp++;
        if (flags !== 9'b0_1_0_1_0_0_0_00) begin
            n_err++;
            $display("FAIL reset_flags got %b want %b", flags, 9'b0_1_0_1_0_0_0_00);
        end
        n_cmp++;
        if (bus.count !== 6'd0 || bus.rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_count_rdata got count=%0d rdata=%h want 0/0", bus.count, bus.rdata);
        end
        // six writes, one read -> count 5 with nonzero rdata
        for (int i = 0; i < 6; i++) begin
            bus.wclken = 1'b1;
            bus.wdata  = 32'hA0 + 32'(i);
            tick();
        end
        bus.wclken = 1'b0;
        bus.rinc   = 1'b1;
        tick();
        bus.rinc   = 1'b0;
        n_cmp++;
        if (bus.count !== 6'd5 || bus.rdata !== 32'hA0 || bus.rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_state got count=%0d rdata=%h rvalid=%b want 5/a0/1",
                     bus.count, bus.rdata, bus.rvalid);
        end
        // asynchronous reset with no clock edge in between
        wrst = 1'b1;
        #1;
        n_cmp++;
        if (bus.count !== 6'd0 || bus.rempty !== 1'b1 || bus.rdata !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset got count=%0d rempty=%b rdata=%h want 0/1/0",
                     bus.count, bus.rempty, bus.rdata);
        end
        @(negedge wclk);
        wrst = 1'b0;
        tick();
        bus.wclken = 1'b1;
        bus.wdata  = 32'h55;
        tick();
        bus.wclken = 1'b0;
        bus.rinc   = 1'b1;
        tick();
        bus.rinc   = 1'b0;
        n_cmp++;
        if (bus.rdata !== 32'h55 || bus.rvalid !== 1'b1 || bus.rempty !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_read got rdata=%h rvalid=%b rempty=%b want 55/1/1",
                     bus.rdata, bus.rvalid, bus.rempty);
        end
        tick();
    endtask

    task automatic test_fill;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            bus.wclken = 1'b1;
            bus.wdata  = 32'(i);
            tick();
            n_cmp++;
            if (bus.count !== 6'(i + 1) || bus.afull !== (i + 1 >= 28) || bus.wfull !== (i + 1 == 32)
                || bus.rempty !== 1'b0 || bus.aempty !== (i + 1 <= 4)) begin
                n_err++;
                $display("FAIL fill_%0d got count=%0d afull=%b wfull=%b aempty=%b rempty=%b",
                         i, bus.count, bus.afull, bus.wfull, bus.aempty, bus.rempty);
            end
        end
        bus.wdata = 32'hDEAD;
        tick();
        bus.wclken = 1'b0;
        n_cmp++;
        if (bus.overflow !== 1'b1 || bus.count !== 6'd32 || bus.wfull !== 1'b1 || bus.underflow !== 1'b0) begin
            n_err++;
            $display("FAIL fill_overflow got ovf=%b count=%0d wfull=%b unf=%b want 1/32/1/0",
                     bus.overflow, bus.count, bus.wfull, bus.underflow);
        end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 32; i++) begin
            bus.rinc = 1'b1;
            tick();
            n_cmp++;
            if (bus.rdata !== 32'(i) || bus.rvalid !== 1'b1 || bus.count !== 6'(31 - i)
                || bus.aempty !== (31 - i <= 4) || bus.rempty !== (i == 31) || bus.wfull !== 1'b0
                || bus.afull !== (31 - i >= 28)) begin
                n_err++;
                $display("FAIL drain_%0d got rdata=%0d rvalid=%b count=%0d aempty=%b rempty=%b",
                         i, bus.rdata, bus.rvalid, bus.count, bus.aempty, bus.rempty);
            end
        end
        tick();
        bus.rinc = 1'b0;
        n_cmp++;
        if (bus.underflow !== 1'b1 || bus.rvalid !== 1'b0 || bus.count !== 6'd0 || bus.rdata !== 32'd31) begin
            n_err++;
            $display("FAIL drain_underflow got unf=%b rvalid=%b count=%0d rdata=%0d want 1/0/0/31",
                     bus.underflow, bus.rvalid, bus.count, bus.rdata);
        end
    endtask

    task automatic test_simultaneous;
        do_reset();
        bus.wclken = 1'b1;
        bus.rinc   = 1'b1;
        bus.wdata  = 32'h100;
        tick();
        n_cmp++;
        if (bus.count !== 6'd1 || bus.underflow !== 1'b1 || bus.rvalid !== 1'b0 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL both_at_empty got count=%0d unf=%b rvalid=%b ovf=%b want 1/1/0/0",
                     bus.count, bus.underflow, bus.rvalid, bus.overflow);
        end
        bus.rinc = 1'b0;
        for (int i = 1; i < 32; i++) begin
            bus.wdata = 32'h100 + 32'(i);
            tick();
        end
        bus.rinc  = 1'b1;
        bus.wdata = 32'hBAD;
        tick();
        n_cmp++;
        if (bus.count !== 6'd31 || bus.overflow !== 1'b1 || bus.rdata !== 32'h100 || bus.rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL both_at_full got count=%0d ovf=%b rdata=%h rvalid=%b want 31/1/100/1",
                     bus.count, bus.overflow, bus.rdata, bus.rvalid);
        end
        bus.wclken = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        bus.wclken = 1'b1;
        bus.wdata  = 32'h200;
        tick();
        bus.wclken = 1'b0;
        bus.rinc   = 1'b0;
        // words 0x101..0x115 read so far; the both-cycle pops 0x116
        n_cmp++;
        if (bus.count !== 6'd10 || bus.rdata !== 32'h116 || bus.rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL both_at_ten got count=%0d rdata=%h rvalid=%b want 10/116/1",
                     bus.count, bus.rdata, bus.rvalid);
        end
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic [31:0] exp_rdata;
        logic        exp_ovf;
        logic        exp_unf;
        logic        exp_rvalid;
        logic        full_pre;
        logic        empty_pre;
        logic        wr;
        logic        rd;
        int          n;
        logic [6:0]  got;
        logic [6:0]  want;
        do_reset();
        exp_rdata = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        for (int c = 0; c < 200; c++) begin
            full_pre   = (q.size() == 32);
            empty_pre  = (q.size() == 0);
            wr         = 1'($urandom_range(0, 1));
            rd         = 1'($urandom_range(0, 1));
            bus.wclken = wr;
            bus.rinc   = rd;
            bus.wdata  = $urandom;
            exp_rvalid = rd && !empty_pre;
            if (exp_rvalid) exp_rdata = q.pop_front();
            if (wr && !full_pre) q.push_back(bus.wdata);
            exp_ovf = exp_ovf | (wr & full_pre);
            exp_unf = exp_unf | (rd & empty_pre);
            tick();
            n    = q.size();
            got  = {bus.wfull, bus.rempty, bus.afull, bus.aempty, bus.rvalid, bus.overflow, bus.underflow};
            want = {n == 32, n == 0, n >= 28, n <= 4, exp_rvalid, exp_ovf, exp_unf};
            n_cmp++;
            if (got !== want || bus.count !== 6'(n) || bus.rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL random_cycle_%0d got flags=%b count=%0d rdata=%h want flags=%b count=%0d rdata=%h",
                         c, got, bus.count, bus.rdata, want, n, exp_rdata);
            end
        end
        idle_inputs();
    endtask

    task automatic test_sweep;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sbus.wclken = 1'b1;
            sbus.wdata  = 8'h10 + 8'(i);
            tick();
            n_cmp++;
            if (sbus.count !== 3'(i + 1) || sbus.wfull !== (i == 3) || sbus.afull !== (i + 1 >= 3)
                || sbus.aempty !== (i + 1 <= 1) || sbus.rempty !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_fill_%0d got count=%0d wfull=%b afull=%b aempty=%b",
                         i, sbus.count, sbus.wfull, sbus.afull, sbus.aempty);
            end
        end
        tick();
        sbus.wclken = 1'b0;
        n_cmp++;
        if (sbus.overflow !== 1'b1 || sbus.count !== 3'd4) begin
            n_err++;
            $display("FAIL sweep_overflow got ovf=%b count=%0d want 1/4", sbus.overflow, sbus.count);
        end
        for (int i = 0; i < 4; i++) begin
            sbus.rinc = 1'b1;
            tick();
            n_cmp++;
            if (sbus.rdata !== 8'h10 + 8'(i) || sbus.rvalid !== 1'b1 || sbus.count !== 3'(3 - i)
                || sbus.aempty !== (3 - i <= 1) || sbus.rempty !== (i == 3)) begin
                n_err++;
                $display("FAIL sweep_drain_%0d got rdata=%h rvalid=%b count=%0d aempty=%b rempty=%b",
                         i, sbus.rdata, sbus.rvalid, sbus.count, sbus.aempty, sbus.rempty);
            end
        end
        sbus.rinc = 1'b0;
        // preload two words, then stream through several pointer wraps
        sbus.wclken = 1'b1;
        sbus.wdata  = 8'h20;
        tick();
        sbus.wdata  = 8'h21;
        tick();
        sbus.rinc = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sbus.wdata = 8'h22 + 8'(k);
            tick();
            n_cmp++;
            if (sbus.rdata !== 8'h20 + 8'(k) || sbus.rvalid !== 1'b1 || sbus.count !== 3'd2) begin
                n_err++;
                $display("FAIL sweep_wrap_%0d got rdata=%h rvalid=%b count=%0d want %h/1/2",
                         k, sbus.rdata, sbus.rvalid, sbus.count, 8'h20 + 8'(k));
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        wrst  = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_random();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
